// File: rtl/tl_dma_copy.sv
// tl_dma_copy: TileLink host engine that copies a block of memory beat by beat
// through the CCX DMA port. It issues one single-beat Get, waits for the data,
// writes it back with one PutFullData, and then moves on to the next beat.
// Only one TL request is ever in flight.
//
// Build option: define TL_DMA_COPY_FILL_EN to add cmd_fill_i/cmd_pattern_i.
// A fill command writes a constant pattern to the destination and issues no reads.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready_o high; waits for a command
// RD_REQ  | Get to the current source beat presented on channel A
// RD_RESP | waits for AccessAckData; the data goes into the beat buffer
// WR_REQ  | PutFullData of the beat buffer to the current destination beat
// WR_RESP | waits for AccessAck, then advances the pointers or finishes
// FINISH  | done_o pulses for one cycle with error_o, then returns to IDLE
module tl_dma_copy #(
  parameter int DataWidth   = 128,
  parameter int AddrWidth   = 38,
  parameter int SourceWidth = 3,
  parameter int SinkWidth   = 4,
  parameter int LenWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_src_i,
  input  logic [AddrWidth-1:0]   cmd_dst_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
`ifdef TL_DMA_COPY_FILL_EN
  input  logic                   cmd_fill_i,
  input  logic [DataWidth-1:0]   cmd_pattern_i,
`endif
  output logic                   done_o,
  output logic                   error_o,

  // A channel
  output logic                   host_a_valid,
  input  logic                   host_a_ready,
  output logic [2:0]             host_a_opcode,
  output logic [2:0]             host_a_param,
  output logic [3:0]             host_a_size,
  output logic [SourceWidth-1:0] host_a_source,
  output logic [AddrWidth-1:0]   host_a_address,
  output logic [DataWidth/8-1:0] host_a_mask,
  output logic [DataWidth-1:0]   host_a_data,
  output logic                   host_a_corrupt,

  // B channel
  input  logic                   host_b_valid,
  output logic                   host_b_ready,
  input  logic [2:0]             host_b_opcode,
  input  logic [1:0]             host_b_param,
  input  logic [3:0]             host_b_size,
  input  logic [SourceWidth-1:0] host_b_source,
  input  logic [AddrWidth-1:0]   host_b_address,
  input  logic [DataWidth/8-1:0] host_b_mask,
  input  logic [DataWidth-1:0]   host_b_data,
  input  logic                   host_b_corrupt,

  // C channel
  output logic                   host_c_valid,
  input  logic                   host_c_ready,
  output logic [2:0]             host_c_opcode,
  output logic [2:0]             host_c_param,
  output logic [3:0]             host_c_size,
  output logic [SourceWidth-1:0] host_c_source,
  output logic [AddrWidth-1:0]   host_c_address,
  output logic [DataWidth-1:0]   host_c_data,
  output logic                   host_c_corrupt,

  // D channel
  input  logic                   host_d_valid,
  output logic                   host_d_ready,
  input  logic [2:0]             host_d_opcode,
  input  logic [1:0]             host_d_param,
  input  logic [3:0]             host_d_size,
  input  logic [SourceWidth-1:0] host_d_source,
  input  logic [SinkWidth-1:0]   host_d_sink,
  input  logic                   host_d_denied,
  input  logic [DataWidth-1:0]   host_d_data,
  input  logic                   host_d_corrupt,

  // E channel
  output logic                   host_e_valid,
  input  logic                   host_e_ready,
  output logic [SinkWidth-1:0]   host_e_sink
);

  localparam int BeatBytes = DataWidth / 8;
  localparam int OffWidth  = $clog2(BeatBytes);

  localparam logic [3:0]           BeatSize  = 4'(OffWidth);
  localparam logic [AddrWidth-1:0] BeatInc   = AddrWidth'(BeatBytes);
  localparam logic [2:0]           OpGet     = 3'd4;
  localparam logic [2:0]           OpPutFull = 3'd0;
  localparam logic [2:0]           OpAck     = 3'd0;
  localparam logic [2:0]           OpAckData = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_REQ,
    WR_RESP,
    FINISH
  } state_e;

  state_e                 state;
  logic [AddrWidth-1:0]   src_q;
  logic [AddrWidth-1:0]   dst_q;
  logic [LenWidth-1:0]    remaining;
  logic [DataWidth-1:0]   buffer;
  logic                   fill_q;

  logic [AddrWidth-1:0]   src_nxt;
  logic [AddrWidth-1:0]   dst_nxt;
  logic                   cmd_fill;
  logic [DataWidth-1:0]   cmd_pattern;
  logic                   src_misaligned;
  logic                   dst_misaligned;
  logic                   cmd_bad_align;
  logic                   rd_ok;
  logic                   wr_ok;

`ifdef TL_DMA_COPY_FILL_EN
  assign cmd_fill    = cmd_fill_i;
  assign cmd_pattern = cmd_pattern_i;
`else
  assign cmd_fill    = 1'b0;
  assign cmd_pattern = '0;
`endif

  // Pointer increments wrap modulo 2^AddrWidth by construction.
  assign src_nxt = src_q + BeatInc;
  assign dst_nxt = dst_q + BeatInc;

  assign src_misaligned = |cmd_src_i[OffWidth-1:0];
  assign dst_misaligned = |cmd_dst_i[OffWidth-1:0];
  // A fill never reads, so the source address does not matter.
  assign cmd_bad_align  = dst_misaligned | (src_misaligned & ~cmd_fill);

  assign rd_ok = (host_d_opcode == OpAckData) & ~host_d_denied & ~host_d_corrupt;
  assign wr_ok = (host_d_opcode == OpAck) & ~host_d_denied;

  // Fixed A-channel fields. The data lane is the buffer register, so Put data
  // stays stable during an A stall.
  assign host_a_param   = 3'd0;
  assign host_a_size    = BeatSize;
  assign host_a_source  = '0;
  assign host_a_mask    = '1;
  assign host_a_data    = buffer;
  assign host_a_corrupt = 1'b0;

  // The engine never takes probes and never releases, so B is always accepted and C/E stay idle.
  assign host_b_ready   = 1'b1;
  assign host_c_valid   = 1'b0;
  assign host_c_opcode  = 3'd0;
  assign host_c_param   = 3'd0;
  assign host_c_size    = 4'd0;
  assign host_c_source  = '0;
  assign host_c_address = '0;
  assign host_c_data    = '0;
  assign host_c_corrupt = 1'b0;
  assign host_e_valid   = 1'b0;
  assign host_e_sink    = '0;

  logic unused_inputs;
  assign unused_inputs = ^{host_b_valid, host_b_opcode, host_b_param, host_b_size,
                           host_b_source, host_b_address, host_b_mask, host_b_data,
                           host_b_corrupt, host_c_ready, host_e_ready, host_d_param,
                           host_d_size, host_d_source, host_d_sink};

  // Sequencer: state, datapath registers and all handshake outputs in one place
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cmd_ready_o    <= 1'b1;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      host_a_valid   <= 1'b0;
      host_d_ready   <= 1'b0;
      host_a_opcode  <= 3'd0;
      host_a_address <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      remaining      <= '0;
      buffer         <= '0;
      fill_q         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            error_o     <= 1'b0;
            src_q       <= cmd_src_i;
            dst_q       <= cmd_dst_i;
            remaining   <= cmd_len_i;
            fill_q      <= cmd_fill;
            if (cmd_len_i == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else if (cmd_bad_align) begin
              state   <= FINISH;
              done_o  <= 1'b1;
              error_o <= 1'b1;
            end else if (cmd_fill) begin
              buffer         <= cmd_pattern;
              state          <= WR_REQ;
              host_a_valid   <= 1'b1;
              host_a_opcode  <= OpPutFull;
              host_a_address <= cmd_dst_i;
            end else begin
              state          <= RD_REQ;
              host_a_valid   <= 1'b1;
              host_a_opcode  <= OpGet;
              host_a_address <= cmd_src_i;
            end
          end
        end

        RD_REQ: begin
          if (host_a_ready) begin
            host_a_valid <= 1'b0;
            host_d_ready <= 1'b1;
            state        <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (host_d_valid) begin
            host_d_ready <= 1'b0;
            if (rd_ok) begin
              buffer         <= host_d_data;
              state          <= WR_REQ;
              host_a_valid   <= 1'b1;
              host_a_opcode  <= OpPutFull;
              host_a_address <= dst_q;
            end else begin
              state   <= FINISH;
              done_o  <= 1'b1;
              error_o <= 1'b1;
            end
          end
        end

        WR_REQ: begin
          if (host_a_ready) begin
            host_a_valid <= 1'b0;
            host_d_ready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (host_d_valid) begin
            host_d_ready <= 1'b0;
            if (wr_ok) begin
              remaining <= remaining - LenWidth'(1);
              dst_q     <= dst_nxt;
              if (!fill_q) begin
                src_q <= src_nxt;
              end
              if (remaining == LenWidth'(1)) begin
                state  <= FINISH;
                done_o <= 1'b1;
              end else if (fill_q) begin
                state          <= WR_REQ;
                host_a_valid   <= 1'b1;
                host_a_opcode  <= OpPutFull;
                host_a_address <= dst_nxt;
              end else begin
                state          <= RD_REQ;
                host_a_valid   <= 1'b1;
                host_a_opcode  <= OpGet;
                host_a_address <= src_nxt;
              end
            end else begin
              state   <= FINISH;
              done_o  <= 1'b1;
              error_o <= 1'b1;
            end
          end
        end

        FINISH: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          cmd_ready_o  <= 1'b1;
          host_a_valid <= 1'b0;
          host_d_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_dma_copy.sv
// Directed bench for tl_dma_copy: a small TL memory responder with optional
// stalls and error injection, request log, and hand-computed expectations.
`timescale 1ns/1ps
module tb_tl_dma_copy;

  localparam int DW = 128;
  localparam int AW = 38;
  localparam int SW = 3;
  localparam int KW = 4;
  localparam int LW = 16;
  localparam int MW = DW / 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          rst_b;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
`ifdef TL_DMA_COPY_FILL_EN
  logic          cmd_fill;
  logic [DW-1:0] cmd_pattern;
`endif
  logic          done;
  logic          error;

  logic          a_valid, a_ready, a_corrupt;
  logic [2:0]    a_opcode, a_param;
  logic [3:0]    a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [MW-1:0] a_mask;
  logic [DW-1:0] a_data;
  logic          b_ready;
  logic          c_valid, c_corrupt;
  logic [2:0]    c_opcode, c_param;
  logic [3:0]    c_size;
  logic [SW-1:0] c_source;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_data;
  logic          d_valid, d_ready, d_denied;
  logic [2:0]    d_opcode;
  logic [DW-1:0] d_data;
  logic          e_valid;
  logic [KW-1:0] e_sink;

  tl_dma_copy dut (
    .clk_i(clk_sys), .rst_ni(rst_b),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
`ifdef TL_DMA_COPY_FILL_EN
    .cmd_fill_i(cmd_fill), .cmd_pattern_i(cmd_pattern),
`endif
    .done_o(done), .error_o(error),
    .host_a_valid(a_valid), .host_a_ready(a_ready), .host_a_opcode(a_opcode),
    .host_a_param(a_param), .host_a_size(a_size), .host_a_source(a_source),
    .host_a_address(a_address), .host_a_mask(a_mask), .host_a_data(a_data),
    .host_a_corrupt(a_corrupt),
    .host_b_valid(1'b0), .host_b_ready(b_ready), .host_b_opcode(3'd0),
    .host_b_param(2'd0), .host_b_size(4'd0), .host_b_source(3'd0),
    .host_b_address(38'd0), .host_b_mask(16'd0), .host_b_data(128'd0),
    .host_b_corrupt(1'b0),
    .host_c_valid(c_valid), .host_c_ready(1'b1), .host_c_opcode(c_opcode),
    .host_c_param(c_param), .host_c_size(c_size), .host_c_source(c_source),
    .host_c_address(c_address), .host_c_data(c_data), .host_c_corrupt(c_corrupt),
    .host_d_valid(d_valid), .host_d_ready(d_ready), .host_d_opcode(d_opcode),
    .host_d_param(2'd0), .host_d_size(4'd4), .host_d_source(3'd0),
    .host_d_sink(4'd0), .host_d_denied(d_denied), .host_d_data(d_data),
    .host_d_corrupt(1'b0),
    .host_e_valid(e_valid), .host_e_ready(1'b1), .host_e_sink(e_sink)
  );

  typedef struct packed {
    logic [2:0]    opcode;
    logic [2:0]    param;
    logic [3:0]    size;
    logic [SW-1:0] source;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } req_t;

  req_t          req_log[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int n_cmp = 0;
  int n_bad = 0;

  // responder controls, written by the main sequence
  logic stall_en  = 1'b0;
  logic deny_get  = 1'b0;
  logic put_bad   = 1'b0;
  logic block_put = 1'b0;

  // responder/monitor state
  logic          have_req;
  int            wait_cnt;
  req_t          cur_req;
  int            overlap_err = 0;
  int            stable_err  = 0;
  int            av_cnt      = 0;
  int            done_cnt    = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TL memory responder and protocol monitor, acting at the negative edge
  initial begin
    req_t held;
    req_t cur;
    logic held_v;
    held_v   = 1'b0;
    have_req = 1'b0;
    wait_cnt = 0;
    a_ready  = 1'b0;
    d_valid  = 1'b0;
    d_opcode = 3'd0;
    d_denied = 1'b0;
    d_data   = '0;
    forever begin
      @(negedge clk_sys);
      if (!rst_b) begin
        have_req = 1'b0;
        held_v   = 1'b0;
        a_ready  = 1'b0;
        d_valid  = 1'b0;
        continue;
      end
      if (a_valid && d_ready) overlap_err++;
      if (a_valid) av_cnt++;
      if (done) done_cnt++;
      cur = '{opcode: a_opcode, param: a_param, size: a_size, source: a_source,
              addr: a_address, mask: a_mask, data: a_data};
      if (held_v && a_valid && (cur != held)) stable_err++;
      held_v = 1'b0;
      if (!have_req) begin
        d_valid = 1'b0;
        a_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (block_put && a_opcode == 3'd0) a_ready = 1'b0;
        if (a_valid) begin
          if (a_ready) begin
            req_log.push_back(cur);
            if (cur.opcode == 3'd0) mem[cur.addr] = cur.data;
            cur_req  = cur;
            have_req = 1'b1;
            wait_cnt = stall_en ? int'($urandom_range(0, 2)) : 0;
          end else begin
            held   = cur;
            held_v = 1'b1;
          end
        end
      end else begin
        a_ready = 1'b0;
        if (wait_cnt > 0) begin
          wait_cnt--;
          d_valid = 1'b0;
        end else begin
          d_valid = 1'b1;
          if (cur_req.opcode == 3'd4) begin
            d_opcode = 3'd1;
            d_data   = mem.exists(cur_req.addr) ? mem[cur_req.addr] : '0;
            d_denied = deny_get;
          end else begin
            d_opcode = put_bad ? 3'd1 : 3'd0;
            d_data   = '0;
            d_denied = 1'b0;
          end
          if (d_ready) have_req = 1'b0;
        end
      end
    end
  end

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run_cmd(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] n, input logic f, input logic [DW-1:0] p,
                         output int lat, output logic err);
    int   d0;
    logic seen;
    @(negedge clk_sys);
    check_val({tag, "_ready"}, cmd_ready, 1'b1);
    d0        = done_cnt;
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = n;
`ifdef TL_DMA_COPY_FILL_EN
    cmd_fill    = f;
    cmd_pattern = p;
`else
    if (f || (p != '0)) $display("note: fill arguments ignored in copy-only build");
`endif
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    lat  = 0;
    err  = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 2000) begin
      @(negedge clk_sys);
      lat++;
      if (done) begin
        seen = 1'b1;
        err  = error;
      end
    end
    check_val({tag, "_done"}, seen, 1'b1);
    repeat (3) @(negedge clk_sys);
    check_val({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int            lat;
    logic          err;
    int            av0;
    logic          seen;
    logic [DW-1:0] pat;
    logic [DW-1:0] a5;
    rst_b     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
`ifdef TL_DMA_COPY_FILL_EN
    cmd_fill    = 1'b0;
    cmd_pattern = '0;
`endif
    repeat (3) @(posedge clk_sys);
    #1;
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_done", done, 1'b0);
    check_val("rst_error", error, 1'b0);
    check_val("rst_a_valid", a_valid, 1'b0);
    check_val("rst_d_ready", d_ready, 1'b0);
    @(negedge clk_sys);
    rst_b = 1'b1;

    // single beat copy
    a5 = {16{8'hA5}};
    mem[38'h1000] = a5;
    req_log.delete();
    run_cmd("copy1", 38'h1000, 38'h2000, 16'd1, 1'b0, '0, lat, err);
    check_val("copy1_err", err, 1'b0);
    check_val("copy1_latency", lat, 5);
    check_val("copy1_nreq", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check_val("copy1_get_op", req_log[0].opcode, 3'd4);
      check_val("copy1_get_addr", req_log[0].addr, 38'h1000);
      check_val("copy1_get_size", req_log[0].size, 4'd4);
      check_val("copy1_get_mask", req_log[0].mask, 16'hFFFF);
      check_val("copy1_get_src", req_log[0].source, 3'd0);
      check_val("copy1_put_op", req_log[1].opcode, 3'd0);
      check_val("copy1_put_addr", req_log[1].addr, 38'h2000);
      check_val("copy1_put_data", req_log[1].data, a5);
      check_val("copy1_put_mask", req_log[1].mask, 16'hFFFF);
    end

    // four beats with random stalls on both channels
    for (int i = 0; i < 4; i++) mem[AW'(i * 16)] = {4{32'hC0DE_0000 | 32'(i)}};
    req_log.delete();
    stall_en = 1'b1;
    run_cmd("copy4", 38'h0, 38'h100, 16'd4, 1'b0, '0, lat, err);
    stall_en = 1'b0;
    check_val("copy4_err", err, 1'b0);
    check_val("copy4_nreq", req_log.size(), 8);
    if (req_log.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("copy4_get%0d", i), {req_log[2*i].opcode, req_log[2*i].addr},
                  {3'd4, AW'(i * 16)});
        check_val($sformatf("copy4_put%0d", i), {req_log[2*i+1].opcode, req_log[2*i+1].addr},
                  {3'd0, AW'(38'h100 + i * 16)});
        check_val($sformatf("copy4_mem%0d", i), mem[AW'(38'h100 + i * 16)],
                  {4{32'hC0DE_0000 | 32'(i)}});
      end
    end
    check_val("copy4_a_stable", stable_err, 0);

    // zero length: immediate done, no traffic
    av0 = av_cnt;
    run_cmd("len0", 38'h40, 38'h80, 16'd0, 1'b0, '0, lat, err);
    check_val("len0_latency", lat, 1);
    check_val("len0_err", err, 1'b0);
    check_val("len0_no_a", av_cnt - av0, 0);

    // misaligned destination
    av0 = av_cnt;
    run_cmd("misal", 38'h1000, 38'h1008, 16'd1, 1'b0, '0, lat, err);
    check_val("misal_err", err, 1'b1);
    check_val("misal_no_a", av_cnt - av0, 0);

    // denied Get: no Put follows
    req_log.delete();
    deny_get = 1'b1;
    run_cmd("deny", 38'h1000, 38'h4000, 16'd2, 1'b0, '0, lat, err);
    deny_get = 1'b0;
    check_val("deny_err", err, 1'b1);
    check_val("deny_nreq", req_log.size(), 1);

    // Put answered with AccessAckData
    req_log.delete();
    put_bad = 1'b1;
    run_cmd("putbad", 38'h1000, 38'h5000, 16'd1, 1'b0, '0, lat, err);
    put_bad = 1'b0;
    check_val("putbad_err", err, 1'b1);
    check_val("putbad_nreq", req_log.size(), 2);

    // source address wraps to zero; error flag cleared by the new command
    req_log.delete();
    run_cmd("wrap", 38'h3F_FFFF_FFF0, 38'h6000, 16'd2, 1'b0, '0, lat, err);
    check_val("wrap_err", err, 1'b0);
    check_val("wrap_nreq", req_log.size(), 4);
    if (req_log.size() == 4) begin
      check_val("wrap_get1", {req_log[2].opcode, req_log[2].addr}, {3'd4, 38'h0});
      check_val("wrap_put1", {req_log[3].opcode, req_log[3].addr}, {3'd0, 38'h6010});
    end

`ifdef TL_DMA_COPY_FILL_EN
    pat = {4{32'hDEAD_BEEF}};
    req_log.delete();
    run_cmd("fill", 38'h1004, 38'h3000, 16'd3, 1'b1, pat, lat, err);
    check_val("fill_err", err, 1'b0);
    check_val("fill_nreq", req_log.size(), 3);
    if (req_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("fill_put%0d", i), {req_log[i].opcode, req_log[i].addr},
                  {3'd0, AW'(38'h3000 + i * 16)});
        check_val($sformatf("fill_data%0d", i), req_log[i].data, pat);
      end
    end
`else
    pat = '0;
`endif

    // reset while a Put is stalled on channel A
    block_put = 1'b1;
    @(negedge clk_sys);
    cmd_valid = 1'b1;
    cmd_src   = 38'h1000;
    cmd_dst   = 38'h7000;
    cmd_len   = 16'd1;
`ifdef TL_DMA_COPY_FILL_EN
    cmd_fill  = 1'b0;
`endif
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_sys);
      if (a_valid && a_opcode == 3'd0) seen = 1'b1;
    end
    check_val("rstmid_reach_wr", seen, 1'b1);
    rst_b = 1'b0;
    @(posedge clk_sys);
    #1;
    check_val("rstmid_a_valid", a_valid, 1'b0);
    check_val("rstmid_cmd_ready", cmd_ready, 1'b1);
    check_val("rstmid_done", done, 1'b0);
    @(negedge clk_sys);
    rst_b     = 1'b1;
    block_put = 1'b0;

    // engine recovers after the mid-operation reset
    req_log.delete();
    run_cmd("after", 38'h1000, 38'h8000, 16'd1, 1'b0, '0, lat, err);
    check_val("after_err", err, 1'b0);
    check_val("after_nreq", req_log.size(), 2);
    check_val("after_mem", mem[38'h8000], a5);

    check_val("no_a_d_overlap", overlap_err, 0);
    check_val("b_ready_const", b_ready, 1'b1);
    check_val("c_e_idle", {c_valid, e_valid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
